// File: rtl/fetch_unit_if.sv
// Bundles the fetch unit's memory port, executor handshake, redirect and fault signals.
// The master modport is the fetch unit's view; slave is the memory/executor side.
interface fetch_unit_if;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic        fetch_fault;

   modport master (
      input  redirect, redirect_pc, mem_ack, mem_rdata, instr_ready,
      output mem_req, mem_addr, instr_valid, instruction, pc, fetch_fault
   );

   modport slave (
      output redirect, redirect_pc, mem_ack, mem_rdata, instr_ready,
      input  mem_req, mem_addr, instr_valid, instruction, pc, fetch_fault
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: word fetch, instruction hold register and redirect/fault handling.
// Define FETCH_COMPRESSED_EN to add 16-bit instructions via the halfword buffer.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic           clk,
   input logic           rst_n,
   fetch_unit_if.master  bus
);

   typedef enum logic [1:0] {FETCH, HOLD, FAULT} state_t;

   state_t      r_state, w_stateNext;
   logic [31:0] r_fa, w_faNext;
   logic [31:0] r_instr, w_instrNext;
   logic [31:0] r_pc, w_pcNext;
   logic        w_canLoad;
   logic        w_memReq;
   logic        w_misaligned;

`ifdef FETCH_COMPRESSED_EN
   logic [15:0] r_hb, w_hbNext;
   logic [31:0] r_hbPc, w_hbPcNext;
   logic        r_hbV, w_hbVNext;
   logic        r_skip, w_skipNext;
   logic        w_hbFull;

   // A buffered 16-bit instruction can be issued without touching memory
   assign w_hbFull = r_hbV && (r_hb[1:0] != 2'b11);
`endif

   always_comb begin
      w_stateNext  = r_state;
      w_faNext     = r_fa;
      w_instrNext  = r_instr;
      w_pcNext     = r_pc;
      w_memReq     = 1'b0;
      w_misaligned = 1'b0;
      w_canLoad    = (r_state == FETCH) || ((r_state == HOLD) && bus.instr_ready);
`ifdef FETCH_COMPRESSED_EN
      w_hbNext     = r_hb;
      w_hbPcNext   = r_hbPc;
      w_hbVNext    = r_hbV;
      w_skipNext   = r_skip;
`endif

      if (bus.redirect) begin
         w_faNext = {bus.redirect_pc[31:2], 2'b00};
`ifdef FETCH_COMPRESSED_EN
         w_misaligned = bus.redirect_pc[0];
         w_skipNext   = bus.redirect_pc[1];
         w_hbVNext    = 1'b0;
`else
         w_misaligned = |bus.redirect_pc[1:0];
`endif
         w_stateNext = w_misaligned ? FAULT : FETCH;
      end else if ((r_state != FAULT) && w_canLoad) begin
         // Output drains unless something new is loaded below
         w_stateNext = FETCH;
`ifdef FETCH_COMPRESSED_EN
         if (w_hbFull) begin
            w_instrNext = {16'h0000, r_hb};
            w_pcNext    = r_hbPc;
            w_hbVNext   = 1'b0;
            w_stateNext = HOLD;
         end else begin
            w_memReq = 1'b1;
            if (bus.mem_ack) begin
               w_faNext   = r_fa + 32'd4;
               w_skipNext = 1'b0;
               if (r_hbV) begin
                  w_instrNext = {bus.mem_rdata[15:0], r_hb};
                  w_pcNext    = r_hbPc;
                  w_hbNext    = bus.mem_rdata[31:16];
                  w_hbPcNext  = r_hbPc + 32'd4;
                  w_hbVNext   = 1'b1;
                  w_stateNext = HOLD;
               end else if (r_skip) begin
                  // Entered mid-word: only the high half belongs to the stream
                  if (bus.mem_rdata[17:16] == 2'b11) begin
                     w_hbNext   = bus.mem_rdata[31:16];
                     w_hbPcNext = {r_fa[31:2], 2'b10};
                     w_hbVNext  = 1'b1;
                  end else begin
                     w_instrNext = {16'h0000, bus.mem_rdata[31:16]};
                     w_pcNext    = {r_fa[31:2], 2'b10};
                     w_stateNext = HOLD;
                  end
               end else if (bus.mem_rdata[1:0] == 2'b11) begin
                  w_instrNext = bus.mem_rdata;
                  w_pcNext    = r_fa;
                  w_stateNext = HOLD;
               end else begin
                  w_instrNext = {16'h0000, bus.mem_rdata[15:0]};
                  w_pcNext    = r_fa;
                  w_hbNext    = bus.mem_rdata[31:16];
                  w_hbPcNext  = r_fa + 32'd2;
                  w_hbVNext   = 1'b1;
                  w_stateNext = HOLD;
               end
            end
         end
`else
         w_memReq = 1'b1;
         if (bus.mem_ack) begin
            w_faNext    = r_fa + 32'd4;
            w_instrNext = bus.mem_rdata;
            w_pcNext    = r_fa;
            w_stateNext = HOLD;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state <= FETCH;
         r_fa    <= {RESET_PC[31:2], 2'b00};
         r_instr <= 32'h0000_0000;
         r_pc    <= RESET_PC;
`ifdef FETCH_COMPRESSED_EN
         r_hb    <= 16'h0000;
         r_hbPc  <= RESET_PC;
         r_hbV   <= 1'b0;
         r_skip  <= RESET_PC[1];
`endif
      end else begin
         r_state <= w_stateNext;
         r_fa    <= w_faNext;
         r_instr <= w_instrNext;
         r_pc    <= w_pcNext;
`ifdef FETCH_COMPRESSED_EN
         r_hb    <= w_hbNext;
         r_hbPc  <= w_hbPcNext;
         r_hbV   <= w_hbVNext;
         r_skip  <= w_skipNext;
`endif
      end
   end

   // Request is suppressed while reset is held so an in-flight access is abandoned
   assign bus.mem_req     = w_memReq && !rst_n;
   assign bus.mem_addr    = r_fa;
   assign bus.instr_valid = (r_state == HOLD);
   assign bus.instruction = r_instr;
   assign bus.pc          = r_pc;
   assign bus.fetch_fault = (r_state == FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed vector table plus hand sequences
// for reset, halfword assembly, faults and mid-request reset.
module tb_fetch_unit;

   typedef struct {
      logic        redirect;
      logic [31:0] redirectPc;
      logic        ready;
      logic        ackEn;
      logic        ackForce;
      logic        expValid;
      logic [31:0] expInstr;
      logic [31:0] expPc;
      logic        expReq;
      logic [31:0] expAddr;
      logic        expFault;
   } vec_t;

   logic clk;
   logic rst_n;
   logic ackEn;
   logic ackForce;
   int   testCount;
   int   failCount;
   int   ackCount;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Zero-wait memory: each word holds its own address in the top half
   function automatic logic [31:0] memWord(input logic [31:0] a);
      case (a)
         32'h0000_0000: memWord = 32'h4501_4081;
         32'h0000_0200: memWord = 32'h0093_0000;
         32'h0000_0204: memWord = 32'hAAAA_0010;
         default:       memWord = {a[15:0], 16'h0013};
      endcase
   endfunction

   assign bus.mem_ack   = (bus.mem_req && ackEn) || ackForce;
   assign bus.mem_rdata = memWord(bus.mem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_req && bus.mem_ack) ackCount <= ackCount + 1;
   end

   function automatic vec_t mk(input logic red, input logic [31:0] rpc, input logic rdy,
                               input logic aen, input logic afc, input logic v,
                               input logic [31:0] ins, input logic [31:0] p,
                               input logic req, input logic [31:0] addr, input logic flt);
      vec_t t;
      t.redirect = red; t.redirectPc = rpc; t.ready = rdy; t.ackEn = aen; t.ackForce = afc;
      t.expValid = v; t.expInstr = ins; t.expPc = p; t.expReq = req; t.expAddr = addr;
      t.expFault = flt;
      return t;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   // Drives one cycle of inputs; redirect and forced ack are single-cycle pulses
   task automatic applyStimulus(input vec_t v);
      bus.redirect    = v.redirect;
      bus.redirect_pc = v.redirectPc;
      bus.instr_ready = v.ready;
      ackEn           = v.ackEn;
      ackForce        = v.ackForce;
      @(posedge clk);
      #1;
      bus.redirect = 1'b0;
      ackForce     = 1'b0;
      #1;
   endtask

   task automatic checkVec(input string tag, input vec_t v);
      checkOutput({tag, " valid"}, {31'b0, bus.instr_valid}, {31'b0, v.expValid});
      checkOutput({tag, " req"},   {31'b0, bus.mem_req},     {31'b0, v.expReq});
      checkOutput({tag, " addr"},  bus.mem_addr,             v.expAddr);
      checkOutput({tag, " fault"}, {31'b0, bus.fetch_fault}, {31'b0, v.expFault});
      if (v.expValid) begin
         checkOutput({tag, " instr"}, bus.instruction, v.expInstr);
         checkOutput({tag, " pc"},    bus.pc,          v.expPc);
      end
   endtask

   vec_t vecs[18];

   initial begin
      testCount = 0;
      failCount = 0;
      ackCount  = 0;
      //          red rpc           rdy aen afc  v  instr          pc             req addr           flt
      vecs[0]  = mk(0, 32'h0,       1,  1,  0,   1, 32'h0100_0013, 32'h0000_0100, 1, 32'h0000_0104, 0);
      vecs[1]  = mk(0, 32'h0,       1,  1,  0,   1, 32'h0104_0013, 32'h0000_0104, 1, 32'h0000_0108, 0);
      vecs[2]  = mk(0, 32'h0,       0,  1,  0,   1, 32'h0104_0013, 32'h0000_0104, 0, 32'h0000_0108, 0);
      vecs[3]  = mk(0, 32'h0,       0,  1,  0,   1, 32'h0104_0013, 32'h0000_0104, 0, 32'h0000_0108, 0);
      vecs[4]  = mk(0, 32'h0,       0,  1,  0,   1, 32'h0104_0013, 32'h0000_0104, 0, 32'h0000_0108, 0);
      vecs[5]  = mk(0, 32'h0,       0,  1,  0,   1, 32'h0104_0013, 32'h0000_0104, 0, 32'h0000_0108, 0);
      vecs[6]  = mk(0, 32'h0,       0,  1,  0,   1, 32'h0104_0013, 32'h0000_0104, 0, 32'h0000_0108, 0);
      vecs[7]  = mk(0, 32'h0,       1,  1,  0,   1, 32'h0108_0013, 32'h0000_0108, 1, 32'h0000_010C, 0);
      vecs[8]  = mk(0, 32'h0,       1,  0,  0,   0, 32'h0,         32'h0,         1, 32'h0000_010C, 0);
      vecs[9]  = mk(0, 32'h0,       1,  0,  0,   0, 32'h0,         32'h0,         1, 32'h0000_010C, 0);
      vecs[10] = mk(1, 32'h400,     1,  0,  1,   0, 32'h0,         32'h0,         1, 32'h0000_0400, 0);
      vecs[11] = mk(0, 32'h0,       1,  1,  0,   1, 32'h0400_0013, 32'h0000_0400, 1, 32'h0000_0404, 0);
      vecs[12] = mk(1, 32'h401,     1,  1,  0,   0, 32'h0,         32'h0,         0, 32'h0000_0400, 1);
      vecs[13] = mk(0, 32'h0,       1,  1,  0,   0, 32'h0,         32'h0,         0, 32'h0000_0400, 1);
      vecs[14] = mk(1, 32'h403,     1,  1,  0,   0, 32'h0,         32'h0,         0, 32'h0000_0400, 1);
      vecs[15] = mk(1, 32'h500,     1,  1,  0,   0, 32'h0,         32'h0,         1, 32'h0000_0500, 0);
      vecs[16] = mk(0, 32'h0,       1,  1,  0,   1, 32'h0500_0013, 32'h0000_0500, 1, 32'h0000_0504, 0);
      vecs[17] = mk(0, 32'h0,       1,  1,  0,   1, 32'h0504_0013, 32'h0000_0504, 1, 32'h0000_0508, 0);

      rst_n           = 1'b1;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.instr_ready = 1'b1;
      ackEn           = 1'b1;
      ackForce        = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset req",   {31'b0, bus.mem_req},     32'h0);
      checkOutput("reset valid", {31'b0, bus.instr_valid}, 32'h0);
      checkOutput("reset instr", bus.instruction,          32'h0);
      checkOutput("reset pc",    bus.pc,                   32'h0000_0100);
      checkOutput("reset addr",  bus.mem_addr,             32'h0000_0100);
      checkOutput("reset fault", {31'b0, bus.fetch_fault}, 32'h0);

      rst_n = 1'b0;
      #1;
      checkOutput("release req",   {31'b0, bus.mem_req},     32'h1);
      checkOutput("release valid", {31'b0, bus.instr_valid}, 32'h0);

      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i]);
         checkVec($sformatf("vec%0d", i), vecs[i]);
      end

`ifdef FETCH_COMPRESSED_EN
      begin
         vec_t s;
         int   acksBefore;
         s = mk(1, 32'h0, 1, 1, 0, 0, 32'h0, 32'h0, 1, 32'h0, 0);
         applyStimulus(s);
         checkVec("cRedir0", s);
         acksBefore = ackCount;
         s = mk(0, 32'h0, 1, 1, 0, 1, 32'h0000_4081, 32'h0, 0, 32'h4, 0);
         applyStimulus(s);
         checkVec("cLow", s);
         s = mk(0, 32'h0, 1, 1, 0, 1, 32'h0000_4501, 32'h2, 1, 32'h4, 0);
         applyStimulus(s);
         checkVec("cHigh", s);
         checkOutput("cOneAck", ackCount - acksBefore, 32'd1);
         s = mk(1, 32'h202, 1, 1, 0, 0, 32'h0, 32'h0, 1, 32'h200, 0);
         applyStimulus(s);
         checkVec("cRedir202", s);
         s = mk(0, 32'h0, 1, 1, 0, 0, 32'h0, 32'h0, 1, 32'h204, 0);
         applyStimulus(s);
         checkVec("cStraddle1", s);
         s = mk(0, 32'h0, 1, 1, 0, 1, 32'h0010_0093, 32'h202, 0, 32'h208, 0);
         applyStimulus(s);
         checkVec("cStraddle2", s);
         s = mk(1, 32'h500, 1, 1, 0, 0, 32'h0, 32'h0, 1, 32'h500, 0);
         applyStimulus(s);
         checkVec("cRealign", s);
      end
`else
      begin
         vec_t s;
         s = mk(1, 32'h402, 1, 1, 0, 0, 32'h0, 32'h0, 0, 32'h400, 1);
         applyStimulus(s);
         checkVec("halfFault", s);
         s = mk(1, 32'h500, 1, 1, 0, 0, 32'h0, 32'h0, 1, 32'h500, 0);
         applyStimulus(s);
         checkVec("halfClear", s);
      end
`endif

      // Reset while a request is pending abandons it and restarts at RESET_PC
      rst_n = 1'b1;
      #1;
      checkOutput("midReset req", {31'b0, bus.mem_req}, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("midReset valid", {31'b0, bus.instr_valid}, 32'h0);
      checkOutput("midReset pc",    bus.pc,                   32'h0000_0100);
      checkOutput("midReset addr",  bus.mem_addr,             32'h0000_0100);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("restart valid", {31'b0, bus.instr_valid}, 32'h1);
      checkOutput("restart instr", bus.instruction,          32'h0100_0013);
      checkOutput("restart pc",    bus.pc,                   32'h0000_0100);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of `executor` and supplies it with `instruction` and `pc`. It reads 32-bit aligned words from instruction memory over a single-outstanding req/ack port and reassembles 16-bit and 32-bit instructions, including 32-bit instructions that straddle a word boundary. It holds each instruction until the executor accepts it, and restarts at `pc_next` on any executor redirect.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset; synchronous, active-high despite the name. Sampled on `clk`.
- `redirect`  in  1: executor `pc_next` is valid and the fetch stream must restart there.
- `redirect_pc`  in  32: new PC.
- `mem_req`  out  1: word read request.
- `mem_addr`  out  32: word address, bits [1:0] always 0.
- `mem_ack`  in  1: `mem_rdata` is valid this cycle for the current request.
- `mem_rdata`  in  32: read data.
- `instr_valid`  out  1: `instruction`/`pc` are valid.
- `instr_ready`  in  1: executor accepts this cycle (driven as !`wait_sig`).
- `instruction`  out  32: fetched instruction; 16-bit instructions zero-extended.
- `pc`  out  32: address of `instruction`.
- `fetch_fault`  out  1: sticky misaligned-redirect fault.

## Operation
- Registers: word fetch pointer `fa`; output register (`instruction`, `pc`, `instr_valid`); halfword buffer `hb[15:0]`, `hb_pc`, `hb_v`; `fault`.
- States:
  - FETCH: `mem_req`=1, `mem_addr`=`fa`.
  - HOLD: output valid and not yet accepted.
  - FAULT.
- Instruction length: halfword bits [1:0]==2'b11 means 32-bit; otherwise 16-bit.
- Assembly, for next instruction PC `npc`:
  - `npc[1]`=0, word arrives: if 32-bit, emit the whole word. If 16-bit, emit the low half, store the high half in `hb` (`hb_pc`=`npc`+2, `hb_v`=1), and leave `fa` at `fa`+4.
  - `npc[1]`=1 after a redirect: fetch word `npc`&~3. If the high half is 16-bit, emit it. If 32-bit, store it in `hb` and fetch the next word; emit {next.low, hb}.
  - `hb_v` with a 16-bit `hb`: emit `hb` without a memory access.
  - `hb_v` with a 32-bit `hb`: fetch `fa`; emit {word.low, hb}; store word.high in `hb`.
- `mem_req` is asserted only when the output register is empty or being accepted this cycle, and `hb` cannot supply a complete instruction. One request is outstanding at most. `mem_addr` is stable until `mem_ack`.
- Transfer occurs on `instr_valid`&&`instr_ready`. `instruction`/`pc` are stable while `instr_valid`&&!`instr_ready`.
- Redirect has highest priority over ack, handshake and buffer. It clears `instr_valid` and `hb_v`, sets `fa`=`redirect_pc`&~3, and abandons any outstanding request. An ack in the redirect cycle is discarded. The memory slave has no pipelining, so dropping `mem_req` before ack is legal.
- Misaligned redirect (`redirect_pc[0]`=1) enters FAULT:
  - `fetch_fault`=1, `instr_valid`=0, `mem_req`=0.
  - Leaves FAULT only on an aligned redirect or reset.
- Reset values:
  - `mem_req`=0, `instr_valid`=0, `instruction`=0, `pc`=`RESET_PC`, `mem_addr`=`RESET_PC`&~3, `fetch_fault`=0.
  - `hb_v`=0.
  - Reset asserted mid-request abandons the request.

## Timing
- First cycle after reset release: `mem_req`=1.
- Ack in cycle N gives `instr_valid`=1 in N+1.
- Zero-wait memory (ack in the request cycle) with aligned 32-bit code gives one instruction per cycle.
- A 16-bit follow-on from `hb` is valid the cycle after the preceding transfer.
- A straddling instruction costs two acks.
- Redirect in cycle N gives `mem_addr`=new word in N+1; `instr_valid`=0 in N+1.

## Configuration
- `FETCH_COMPRESSED_EN` defined: 16-bit instructions, halfword PCs and `hb` logic as above.
- Not defined:
  - Every instruction is one aligned word; `pc` advances by 4; `hb` is removed.
  - Redirect with `redirect_pc[1:0]`!=0 enters FAULT.
  - The low two bits of the instruction are passed through unchecked; the decoder flags them.

## Test plan
- `RESET_PC`=0x100, zero-wait memory filled with 0x00000013 -> `mem_addr` 0x100, 0x104, 0x108; `instr_valid` every cycle; `pc` +4 per transfer.
- Word 0x0 = 0x45014081 -> `instruction` 0x00004081 at `pc` 0x0, then 0x00004501 at `pc` 0x2; exactly one `mem_req` transaction.
- Redirect 0x202; mem[0x200]=0x00930000, mem[0x204]=0xAAAA0010 -> `instruction` 0x00100093 at `pc` 0x202 after acks for 0x200 and 0x204.
- `instr_ready`=0 for 5 cycles while valid -> `instruction`/`pc` unchanged; no new `mem_req`; transfer on the first ready cycle.
- `mem_ack` held 0; redirect 0x400 -> `mem_addr`=0x400 next cycle; old word never emitted even if acked in the redirect cycle.
- Redirect 0x401 -> `fetch_fault`=1, `mem_req`=0, `instr_valid`=0; redirect 0x500 -> `fetch_fault`=0, `mem_addr`=0x500.
